// File: rtl/rvh_mmu_pkg.sv
// Shared MMU types: page-table-walk scheduler states and walk source encoding.
package rvh_mmu_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_REQ,
        SCHED_WAIT,
        SCHED_RESP
    } sched_state_e;

    localparam logic PTW_SRC_ITLB = 1'b0;
    localparam logic PTW_SRC_DTLB = 1'b1;

endpackage

// File: rtl/rvh_ptw_prio_sel.sv
// Combinational DTLB/ITLB tie-break for the shared page-table walker.
// Produces a one-hot grant indexed by walk source encoding.
module rvh_ptw_prio_sel
    import rvh_mmu_pkg::*;
#(
    parameter int DTLB_PRIOR = 1
) (
    input  logic       i_dtlb_vld,
    input  logic       i_itlb_vld,
    input  logic       i_starved,
    output logic [1:0] o_gnt
);

    localparam logic PRIO_IS_DTLB = (DTLB_PRIOR != 0);

    logic w_tie;
    logic w_dtlb_win;

    assign w_tie = i_dtlb_vld & i_itlb_vld;

    // On a tie the priority side wins, unless the other side has been starved.
    assign w_dtlb_win = w_tie ? (PRIO_IS_DTLB ^ i_starved) : i_dtlb_vld;

    assign o_gnt[PTW_SRC_DTLB] = w_dtlb_win;
    assign o_gnt[PTW_SRC_ITLB] = i_itlb_vld & ~w_dtlb_win;

endmodule

// File: rtl/rvh_ptw_req_sched.sv
// Shares the single page-table walker between DTLB and ITLB misses: one walk outstanding,
// stable request until accepted, response routed to its originator, flush squashes walks.
module rvh_ptw_req_sched
    import rvh_mmu_pkg::*;
#(
    parameter int DTLB_PRIOR = 1,
    parameter int STARVE_MAX = 4,
    parameter int VPN_W      = 27,
    parameter int PPN_W      = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             dtlb_miss_req_vld_i,
    input  logic [VPN_W-1:0] dtlb_miss_req_vpn_i,
    output logic             dtlb_miss_req_rdy_o,
    input  logic             itlb_miss_req_vld_i,
    input  logic [VPN_W-1:0] itlb_miss_req_vpn_i,
    output logic             itlb_miss_req_rdy_o,
    output logic             ptw_req_vld_o,
    output logic [VPN_W-1:0] ptw_req_vpn_o,
    output logic             ptw_req_src_o,
    input  logic             ptw_req_rdy_i,
    input  logic             ptw_resp_vld_i,
    input  logic [PPN_W-1:0] ptw_resp_ppn_i,
    input  logic             ptw_resp_pf_i,
    output logic             dtlb_miss_resp_vld_o,
    output logic             itlb_miss_resp_vld_o,
    output logic [PPN_W-1:0] miss_resp_ppn_o,
    output logic             miss_resp_pf_o,
    output logic             busy_o
);

    localparam int   CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic PRIO_SRC = (DTLB_PRIOR != 0) ? PTW_SRC_DTLB : PTW_SRC_ITLB;

    sched_state_e     r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_kill;
    logic [VPN_W-1:0] r_vpn;
    logic             r_src;
    logic [PPN_W-1:0] r_ppn;
    logic             r_pf;

    logic [1:0] w_gnt;
    logic [1:0] w_acc;
    logic       w_starved;
    logic       w_can_acc;
    logic       w_acc_any;
    logic       w_acc_src;
    logic       w_tie;
    logic       w_resp_fire;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_tie     = dtlb_miss_req_vld_i & itlb_miss_req_vld_i;

    rvh_ptw_prio_sel #(
        .DTLB_PRIOR (DTLB_PRIOR)
    ) u_prio_sel (
        .i_dtlb_vld (dtlb_miss_req_vld_i),
        .i_itlb_vld (itlb_miss_req_vld_i),
        .i_starved  (w_starved),
        .o_gnt      (w_gnt)
    );

    // NOTE: the ready outputs are combinational, so they are gated with rst to stay 0 in reset.
    assign w_can_acc = (r_state == SCHED_IDLE) & ~rst & ~flush_i;
    assign w_acc     = w_gnt & {2{w_can_acc}};
    assign w_acc_any = |w_acc;
    assign w_acc_src = w_acc[PTW_SRC_DTLB];

    assign dtlb_miss_req_rdy_o = w_acc[PTW_SRC_DTLB];
    assign itlb_miss_req_rdy_o = w_acc[PTW_SRC_ITLB];

    assign ptw_req_vld_o = (r_state == SCHED_REQ);
    assign ptw_req_vpn_o = r_vpn;
    assign ptw_req_src_o = r_src;
    assign busy_o        = (r_state != SCHED_IDLE);

    assign w_resp_fire          = (r_state == SCHED_RESP) & ~r_kill & ~flush_i & ~rst;
    assign dtlb_miss_resp_vld_o = w_resp_fire & (r_src == PTW_SRC_DTLB);
    assign itlb_miss_resp_vld_o = w_resp_fire & (r_src == PTW_SRC_ITLB);
    assign miss_resp_ppn_o      = r_ppn;
    assign miss_resp_pf_o       = r_pf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SCHED_IDLE;
            r_starve_cnt <= '0;
            r_kill       <= 1'b0;
            r_vpn        <= '0;
            r_src        <= PTW_SRC_ITLB;
            r_ppn        <= '0;
            r_pf         <= 1'b0;
        end else begin
            case (r_state)
                SCHED_IDLE: begin
                    if (w_acc_any) begin
                        r_state <= SCHED_REQ;
                        r_src   <= w_acc_src;
                        r_vpn   <= w_acc_src ? dtlb_miss_req_vpn_i : itlb_miss_req_vpn_i;
                        if (w_acc_src != PRIO_SRC) begin
                            r_starve_cnt <= '0;
                        end else if (w_tie && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                    end
                end
                SCHED_REQ: begin
                    // A flush racing the handshake still owes the PTW a response to absorb.
                    if (ptw_req_rdy_i) begin
                        r_state <= SCHED_WAIT;
                        r_kill  <= flush_i;
                    end else if (flush_i) begin
                        r_state <= SCHED_IDLE;
                    end
                end
                SCHED_WAIT: begin
                    if (ptw_resp_vld_i) begin
                        if (r_kill || flush_i) begin
                            r_state <= SCHED_IDLE;
                            r_kill  <= 1'b0;
                        end else begin
                            r_state <= SCHED_RESP;
                            r_ppn   <= ptw_resp_ppn_i;
                            r_pf    <= ptw_resp_pf_i;
                        end
                    end else if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                end
                SCHED_RESP: begin
                    r_state <= SCHED_IDLE;
                end
                default: begin
                    r_state <= SCHED_IDLE;
                end
            endcase
        end
    end

    // The walker may only respond while a walk is outstanding.
    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        ptw_resp_vld_i |-> (r_state == SCHED_WAIT));

endmodule
